irq_pending_arbiter: RTL and testbench
======================================

// Module: irq_pending_arbiter
// PURPOSE
//  Collects request lines into a sticky pending register and picks the
//  highest-numbered unmasked pending bit. Presents that bit's index to a
//  downstream consumer over a valid/ready handshake, and clears the bit
//  when the consumer accepts it.
//  Sits upstream of the combinational priority encoder, adding storage,
//  masking and flow control so that a request is never lost.
// PARAMETERS
//  WIDTH   8   number of request lines; index width IW = $clog2(WIDTH)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  req          in   WIDTH  request lines, bit i = source i
//  mask         in   WIDTH  1 = source excluded from selection (pending kept)
//  out_idx      out  IW     index of presented request
//  out_valid    out  1      out_idx valid
//  out_ready    in   1      consumer accepts when out_valid & out_ready
//  pending      out  WIDTH  current sticky pending vector
//  any_pending  out  1      |pending (masked bits included)
// BEHAVIOUR
//  Reset: pending=0, out_idx=0, out_valid=0, any_pending=0, state IDLE,
//   edge history=0. Reset is asynchronous and takes effect mid-handshake.
//   A presented request that was not accepted is discarded.
//  Pending update, every cycle:
//   pending <= (pending & ~clr) | set.
//   set = req, or the rising edges of req (see CONFIGURATION).
//   clr = onehot(out_idx) only in a cycle where out_valid & out_ready.
//   If a bit is set and cleared in the same cycle, set wins and the bit
//   stays pending.
//  Selection: sel = highest i with (pending & ~mask)[i] = 1. Uses
//   registered pending only, so a req asserted in cycle N is selectable
//   in cycle N+1.
//  FSM:
//   IDLE: if |(pending & ~mask), then out_idx<=sel, out_valid<=1, go to
//    PRESENT. Otherwise stay, with out_valid=0.
//   PRESENT: out_idx and out_valid are held stable until out_ready.
//    On out_ready, clear pending[out_idx], out_valid<=0, go to IDLE.
//  Latency: req edge to out_valid is 2 cycles minimum. Throughput is
//   1 grant per 2 cycles.
//  Masking out_idx while in PRESENT does not withdraw it. Once presented,
//   a request is committed.
//  A higher-priority request arriving during PRESENT does not pre-empt.
//   It is taken on the next IDLE.
//  If all pending bits are masked, stay in IDLE with any_pending=1.
//  out_valid must never drop without out_ready, except on reset.
// CONFIGURATION
//  IRQ_EDGE_EN defined:
//   set = req & ~req_q, where req_q is req registered (reset 0).
//   A held-high req produces exactly one grant.
//  IRQ_EDGE_EN undefined:
//   set = req (level mode).
//   A source held high re-pends in the same cycle it is accepted, so it
//   is granted repeatedly, 1 per 2 cycles.
// TESTING (WIDTH=8)
//  1. Reset: assert rst mid-PRESENT.
//     -> out_valid=0, pending=0 asynchronously, without waiting for clk.
//  2. Single request: pulse req=0x10 for 1 cycle, out_ready=1.
//     -> out_valid=1 with out_idx=4 two cycles later; pending=0 after
//        accept.
//  3. Priority and order: pulse req=0x25, out_ready=1.
//     -> grants out_idx 5, 2, 0 in that order, then any_pending=0.
//  4. Stall and hold: req=0x02, out_ready=0 for 5 cycles, then a req=0x80
//     pulse.
//     -> out_idx stays 1 for all 5 cycles; after ready, 7 is granted next.
//  5. Mask: pending=0x81 with mask=0x80.
//     -> grant 0; then with mask=0 -> grant 7.
//     All masked -> out_valid=0, any_pending=1.
//  6. Set/clear collision: re-pulse req[3] in the accept cycle of idx 3.
//     -> pending[3] stays 1 and idx 3 is granted again.
//     Run with and without IRQ_EDGE_EN: req=0x08 held 10 cycles, ready=1.
//     -> 1 grant (edge) vs 5 grants (level).

Source files
------------

// File: rtl/irq_pending_arbiter_if.sv
// Request/grant bundle of irq_pending_arbiter: request and mask lines in,
// indexed grant out over valid/ready, plus visibility of the pending vector.
interface irq_pending_arbiter_if #(
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] mask;
  logic [IW-1:0]    out_idx;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] pending;
  logic             any_pending;

  // The arbiter side
  modport master (
    input  req, mask, out_ready,
    output out_idx, out_valid, pending, any_pending
  );

  // Request sources and grant consumer
  modport slave (
    output req, mask, out_ready,
    input  out_idx, out_valid, pending, any_pending
  );
endinterface

// File: rtl/irq_pending_arbiter.sv
// Sticky pending register with highest-index-first selection, presented over
// valid/ready. Define IRQ_EDGE_EN to pend on rising edges of req instead of level.
module irq_pending_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  irq_pending_arbiter_if.master bus
);
  localparam int IW = $clog2(WIDTH);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] pending_r;
  logic [IW-1:0]    out_idx_r;
  logic             out_valid_r;

  logic [WIDTH-1:0] set_v;
  logic [WIDTH-1:0] clr_v;
  logic [WIDTH-1:0] avail;
  logic [IW-1:0]    sel;
  logic             accept;

`ifdef IRQ_EDGE_EN
  logic [WIDTH-1:0] req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= '0;
    else     req_q <= bus.req;
  end

  assign set_v = bus.req & ~req_q;
`else
  assign set_v = bus.req;
`endif

  assign accept = out_valid_r & bus.out_ready;
  assign avail  = pending_r & ~mask_bits();

  function automatic logic [WIDTH-1:0] mask_bits();
    return bus.mask;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    clr_v = '0;
    if (accept) clr_v[out_idx_r] = 1'b1;
  end

  // Ascending scan: the last hit is the highest unmasked pending index.
  always_comb begin
    sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (avail[i]) sel = IW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      pending_r <= '0;
    end else begin
      // Set is applied after clear so a same-cycle re-request survives.
      pending_r <= (pending_r & ~clr_v) | set_v;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out_idx_r   <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|avail) begin
            out_idx_r   <= sel;
            out_valid_r <= 1'b1;
            state       <= PRESENT;
          end
        end
        PRESENT: begin
          // Committed once presented: mask changes and newer requests wait.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_idx     = out_idx_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.pending     = pending_r;
  assign bus.any_pending = |pending_r;
endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Directed self-checking bench for irq_pending_arbiter (WIDTH=8); expected
// values are hand-computed for the level build, with edge-mode variants.
module tb_irq_pending_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  irq_pending_arbiter_if #(.WIDTH(8)) bus ();

  irq_pending_arbiter #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a presentation, check its index, and if ready is high
  // let it be accepted and confirm valid drops.
  task automatic expect_grant(input string tag, input logic [2:0] idx);
    int n = 0;
    while (!bus.out_valid && n < 8) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_idx"}, 32'(bus.out_idx), 32'(idx));
    if (bus.out_ready) begin
      step();
      check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
    end
  endtask

  task automatic pulse_req(input logic [7:0] v);
    bus.req = v;
    step();
    bus.req = '0;
  endtask

  initial begin
    int grants;
    int exp_grants;

    bus.req       = '0;
    bus.mask      = '0;
    bus.out_ready = 1'b0;

    // Reset asserted before any clock edge: outputs must clear asynchronously.
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    check("rst_any", 32'(bus.any_pending), 32'd0);
    check("rst_idx", 32'(bus.out_idx), 32'd0);
    step();
    step();
    rst = 1'b0;

    // Single request: valid two edges after req is sampled.
    bus.out_ready = 1'b1;
    pulse_req(8'h10);
    check("single_pend", 32'(bus.pending), 32'h10);
    check("single_early", 32'(bus.out_valid), 32'd0);
    step();
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_idx", 32'(bus.out_idx), 32'd4);
    step();
    check("single_clr", 32'(bus.pending), 32'h00);

    // Priority order 5, 2, 0.
    pulse_req(8'h25);
    expect_grant("prio_a", 3'd5);
    check("prio_pend", 32'(bus.pending), 32'h05);
    expect_grant("prio_b", 3'd2);
    expect_grant("prio_c", 3'd0);
    check("prio_any", 32'(bus.any_pending), 32'd0);

    // Stall: idx 1 held for 5 cycles; a higher request meanwhile waits.
    bus.out_ready = 1'b0;
    pulse_req(8'h02);
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) bus.req = 8'h80;
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_idx", 32'(bus.out_idx), 32'd1);
      step();
      bus.req = '0;
    end
    bus.out_ready = 1'b1;
    step();
    check("stall_acc", 32'(bus.out_valid), 32'd0);
    expect_grant("stall_next", 3'd7);

    // Mask: bit 7 excluded, bit 0 granted, bit 7 kept pending.
    bus.mask = 8'h80;
    pulse_req(8'h81);
    expect_grant("mask_lo", 3'd0);
    step();
    step();
    check("mask_all_valid", 32'(bus.out_valid), 32'd0);
    check("mask_all_any", 32'(bus.any_pending), 32'd1);
    check("mask_all_pend", 32'(bus.pending), 32'h80);
    bus.mask = 8'h00;
    expect_grant("mask_hi", 3'd7);

    // Masking a presented index does not withdraw it.
    bus.out_ready = 1'b0;
    pulse_req(8'h04);
    step();
    check("commit_idx", 32'(bus.out_idx), 32'd2);
    bus.mask = 8'h04;
    step();
    check("commit_valid", 32'(bus.out_valid), 32'd1);
    check("commit_idx2", 32'(bus.out_idx), 32'd2);
    bus.out_ready = 1'b1;
    step();
    check("commit_acc", 32'(bus.out_valid), 32'd0);
    bus.mask = 8'h00;
    check("commit_pend", 32'(bus.pending), 32'h00);

    // Set/clear collision: re-request idx 3 in its accept cycle.
    pulse_req(8'h08);
    step();
    check("coll_idx", 32'(bus.out_idx), 32'd3);
    bus.req = 8'h08;
    step();
    bus.req = '0;
    check("coll_pend", 32'(bus.pending), 32'h08);
    check("coll_drop", 32'(bus.out_valid), 32'd0);
    expect_grant("coll_again", 3'd3);
    check("coll_clear", 32'(bus.pending), 32'h00);

    // Held request for 10 cycles: one grant (edge) or five (level).
`ifdef IRQ_EDGE_EN
    exp_grants = 1;
`else
    exp_grants = 5;
`endif
    grants  = 0;
    bus.req = 8'h08;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) bus.req = '0;
      if (bus.out_valid && bus.out_ready) grants++;
      step();
    end
    check("hold_grants", 32'(grants), 32'(exp_grants));
    check("hold_pend", 32'(bus.pending), 32'h00);

    // Reset mid-presentation, between clock edges.
    bus.out_ready = 1'b0;
    pulse_req(8'h40);
    step();
    check("mid_pre_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_pend", 32'(bus.pending), 32'h00);
    check("mid_rst_any", 32'(bus.any_pending), 32'd0);
    step();
    rst = 1'b0;
    step();
    step();
    check("mid_discard", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
